q_redis_seq: RTL and testbench

Phase sequencer for the charge-redistribution compute SRAM macro. It accepts one compute or write request at a time over a valid/ready handshake. It drives every macro control line through the reset, drive, share and sense phases with programmable phase lengths, then returns the sense-amp result over a second valid/ready channel. It sits between the tile controller and the analog macro, and is the only block that drives the macro's control pins.

---
 rtl/q_redis_pkg.sv | 28 ++
 rtl/q_redis_phase_timer.sv | 31 +++
 rtl/q_redis_seq.sv | 267 ++++++++++++++++++++++++++
 tb/tb_q_redis_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_redis_pkg.sv
// Shared types and defaults for the charge-redistribution phase sequencer.
// Phase lengths are cycle counts; a length of 0 is treated as 1.
package q_redis_pkg;

   localparam int CNT_W_DEF = 4;

   localparam int DEF_PCH = 2;
   localparam int DEF_DRV = 2;
   localparam int DEF_SHR = 2;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_RST   = 4'd1,
      S_GAP   = 4'd2,
      S_DRIVE = 4'd3,
      S_SHARE = 4'd4,
      S_SENSE = 4'd5,
      S_RESP  = 4'd6,
      S_WPCH  = 4'd7,
      S_WR    = 4'd8
   } state_e;

   typedef enum logic {
      OP_COMPUTE = 1'b0,
      OP_WRITE   = 1'b1
   } op_e;

endpackage

// File: rtl/q_redis_phase_timer.sv
// Loadable down-counter shared by every phase; o_done flags the last cycle
// of the current phase. A zero length behaves like a length of one.
module q_redis_phase_timer
   import q_redis_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_len,
   output logic             o_done
);

   logic [CNT_W-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= (i_len == '0) ? '0 : i_len - CNT_W'(1);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/q_redis_seq.sv
// Phase sequencer for the charge-redistribution compute SRAM macro: walks the
// macro through reset/drive/share/sense (or precharge/write) and returns the result.
module q_redis_seq
   import q_redis_pkg::*;
#(
   parameter int SRAM_ROWS = 128,
   parameter int SRAM_COLS = 32,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_op,
   input  logic [SRAM_ROWS-1:0] req_rows,
   input  logic                 req_wdata,
   input  logic [CNT_W-1:0]     cfg_pch,
   input  logic [CNT_W-1:0]     cfg_drv,
   input  logic [CNT_W-1:0]     cfg_shr,
   input  logic [SRAM_COLS-1:0] sa_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [SRAM_COLS-1:0] rsp_data,
   output logic [SRAM_ROWS-1:0] VDR_SEL,
   output logic [SRAM_ROWS-1:0] VSS_SEL,
   output logic [SRAM_ROWS-1:0] VRST_SEL,
   output logic [SRAM_ROWS-1:0] VDR_SELB,
   output logic [SRAM_ROWS-1:0] VSS_SELB,
   output logic [SRAM_ROWS-1:0] VRST_SELB,
   output logic                 NF,
   output logic                 M2A,
   output logic                 R2A,
   output logic                 NFB,
   output logic                 M2AB,
   output logic                 R2AB,
   output logic                 PCH,
   output logic                 WR_DATA,
   output logic                 WRITE,
   output logic                 CSEL,
   output logic                 SAEN
);

   state_e r_state;
   state_e w_next;

   logic                 w_accept;
   logic                 w_load;
   logic [CNT_W-1:0]     w_len;
   logic                 w_done;

   logic [SRAM_ROWS-1:0] r_rows;
   logic                 r_wdata;
   logic [CNT_W-1:0]     r_drv;
   logic [CNT_W-1:0]     r_shr;

   logic [SRAM_ROWS-1:0] r_vdr_sel,  w_vdr_sel;
   logic [SRAM_ROWS-1:0] r_vss_sel,  w_vss_sel;
   logic [SRAM_ROWS-1:0] r_vrst_sel, w_vrst_sel;
   logic                 r_nf,  w_nf;
   logic                 r_m2a, w_m2a;
   logic                 r_r2a, w_r2a;
   logic                 r_pch, w_pch;
   logic                 r_wr_data, w_wr_data;
   logic                 r_write,   w_write;
   logic                 r_csel,    w_csel;
   logic                 r_saen,    w_saen;
   logic                 r_req_ready, w_req_ready;
   logic                 r_rsp_valid, w_rsp_valid;
   logic [SRAM_COLS-1:0] r_rsp_data;

   assign w_accept = (r_state == S_IDLE) && req_valid;

   q_redis_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_len  (w_len),
      .o_done (w_done)
   );

   // The timer is reloaded on every transition with the length of the phase
   // being entered; single-cycle phases load zero.
   // NOTE: every signal assigned here gets a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_len  = '0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_next = (op_e'(req_op) == OP_WRITE) ? S_WPCH : S_RST;
               w_load = 1'b1;
               w_len  = cfg_pch;
            end
         end
         S_RST: begin
            if (w_done) begin
               w_next = S_GAP;
               w_load = 1'b1;
            end
         end
         S_GAP: begin
            w_next = S_DRIVE;
            w_load = 1'b1;
            w_len  = r_drv;
         end
         S_DRIVE: begin
            if (w_done) begin
               w_next = S_SHARE;
               w_load = 1'b1;
               w_len  = r_shr;
            end
         end
         S_SHARE: begin
            if (w_done) begin
               w_next = S_SENSE;
               w_load = 1'b1;
            end
         end
         S_SENSE: w_next = S_RESP;
         S_RESP: begin
            if (rsp_ready) w_next = S_IDLE;
         end
         S_WPCH: begin
            if (w_done) begin
               w_next = S_WR;
               w_load = 1'b1;
               w_len  = r_drv;
            end
         end
         S_WR: begin
            if (w_done) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Decoding from the next state lets each phase's levels appear in the
   // very cycle the state is entered, while keeping every pin registered.
   always_comb begin
      w_vdr_sel   = '0;
      w_vss_sel   = '0;
      w_vrst_sel  = '0;
      w_nf        = 1'b0;
      w_m2a       = 1'b0;
      w_r2a       = 1'b0;
      w_pch       = 1'b0;
      w_wr_data   = 1'b0;
      w_write     = 1'b0;
      w_csel      = 1'b0;
      w_saen      = 1'b0;
      w_req_ready = 1'b0;
      w_rsp_valid = 1'b0;
      case (w_next)
         S_IDLE:  w_req_ready = 1'b1;
         S_RST: begin
            w_vrst_sel = '1;
            w_pch      = 1'b1;
         end
         S_DRIVE: begin
            w_vdr_sel = r_rows;
            w_vss_sel = ~r_rows;
            w_m2a     = 1'b1;
         end
         S_SHARE: begin
            w_r2a = 1'b1;
            w_nf  = 1'b1;
         end
         S_SENSE: begin
            w_saen = 1'b1;
            w_nf   = 1'b1;
         end
         S_RESP:  w_rsp_valid = 1'b1;
         S_WPCH:  w_pch = 1'b1;
         S_WR: begin
            w_write   = 1'b1;
            w_csel    = 1'b1;
            w_wr_data = r_wdata;
            w_vdr_sel = r_rows;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_vdr_sel   <= '0;
         r_vss_sel   <= '0;
         r_vrst_sel  <= '0;
         r_nf        <= 1'b0;
         r_m2a       <= 1'b0;
         r_r2a       <= 1'b0;
         r_pch       <= 1'b0;
         r_wr_data   <= 1'b0;
         r_write     <= 1'b0;
         r_csel      <= 1'b0;
         r_saen      <= 1'b0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_vdr_sel   <= w_vdr_sel;
         r_vss_sel   <= w_vss_sel;
         r_vrst_sel  <= w_vrst_sel;
         r_nf        <= w_nf;
         r_m2a       <= w_m2a;
         r_r2a       <= w_r2a;
         r_pch       <= w_pch;
         r_wr_data   <= w_wr_data;
         r_write     <= w_write;
         r_csel      <= w_csel;
         r_saen      <= w_saen;
         r_req_ready <= w_req_ready;
         r_rsp_valid <= w_rsp_valid;
      end
   end

   // The SENSE state always exits to RESP, so capturing here lands the
   // result on the edge that raises rsp_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_data <= '0;
      end else if (r_state == S_SENSE) begin
         r_rsp_data <= sa_out;
      end
   end

   // NOTE: the latched request fields carry no reset; they are only read in
   // states reachable after an accept, which always overwrites them first.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_rows  <= req_rows;
         r_wdata <= req_wdata;
         r_drv   <= cfg_drv;
         r_shr   <= cfg_shr;
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;

   assign VDR_SEL   = r_vdr_sel;
   assign VSS_SEL   = r_vss_sel;
   assign VRST_SEL  = r_vrst_sel;
   assign VDR_SELB  = ~r_vdr_sel;
   assign VSS_SELB  = ~r_vss_sel;
   assign VRST_SELB = ~r_vrst_sel;

   assign NF   = r_nf;
   assign M2A  = r_m2a;
   assign R2A  = r_r2a;
   assign NFB  = ~r_nf;
   assign M2AB = ~r_m2a;
   assign R2AB = ~r_r2a;

   assign PCH     = r_pch;
   assign WR_DATA = r_wr_data;
   assign WRITE   = r_write;
   assign CSEL    = r_csel;
   assign SAEN    = r_saen;

endmodule

// File: tb/tb_q_redis_seq.sv
// Bench for q_redis_seq: a transaction-level model predicts every output each
// cycle from phase windows, plus literal expectations on latency and waveforms.
module tb_q_redis_seq;
   import q_redis_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_op = 1'b0;
   logic [127:0] req_rows = '0;
   logic         req_wdata = 1'b0;
   logic [3:0]   cfg_pch = 4'(DEF_PCH);
   logic [3:0]   cfg_drv = 4'(DEF_DRV);
   logic [3:0]   cfg_shr = 4'(DEF_SHR);
   logic [31:0]  sa_out = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [31:0]  rsp_data;
   logic [127:0] VDR_SEL, VSS_SEL, VRST_SEL, VDR_SELB, VSS_SELB, VRST_SELB;
   logic         NF, M2A, R2A, NFB, M2AB, R2AB;
   logic         PCH, WR_DATA, WRITE, CSEL, SAEN;

   int n_chk = 0;
   int n_err = 0;

   q_redis_seq dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rows(req_rows), .req_wdata(req_wdata),
      .cfg_pch(cfg_pch), .cfg_drv(cfg_drv), .cfg_shr(cfg_shr),
      .sa_out(sa_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .VDR_SEL(VDR_SEL), .VSS_SEL(VSS_SEL), .VRST_SEL(VRST_SEL),
      .VDR_SELB(VDR_SELB), .VSS_SELB(VSS_SELB), .VRST_SELB(VRST_SELB),
      .NF(NF), .M2A(M2A), .R2A(R2A), .NFB(NFB), .M2AB(M2AB), .R2AB(R2AB),
      .PCH(PCH), .WR_DATA(WR_DATA), .WRITE(WRITE), .CSEL(CSEL), .SAEN(SAEN)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int eff(input logic [3:0] c);
      return (c == 4'd0) ? 1 : int'(c);
   endfunction

   // ---------------- transaction model ----------------
   // m_k counts edges since the accept edge; windows below derive from p/d/s.
   bit           m_busy = 1'b0;
   bit           m_write = 1'b0;
   int           m_k = 0, m_p = 1, m_d = 1, m_s = 1;
   logic [127:0] m_rows = '0;
   logic         m_wdata = 1'b0;
   logic [31:0]  m_rsp = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0;
         m_rsp  = '0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy  = 1'b1;
            m_write = req_op;
            m_k     = 0;
            m_p     = eff(cfg_pch);
            m_d     = eff(cfg_drv);
            m_s     = eff(cfg_shr);
            m_rows  = req_rows;
            m_wdata = req_wdata;
         end
      end else if (m_write) begin
         m_k++;
         if (m_k == m_p + m_d) m_busy = 1'b0;
      end else if (m_k == m_p + m_d + m_s + 2) begin
         if (rsp_ready) m_busy = 1'b0;
      end else begin
         if (m_k == m_p + m_d + m_s + 1) m_rsp = sa_out;
         m_k++;
      end
   end

   always @(negedge clk) begin
      logic [127:0] e_vdr, e_vss, e_vrst;
      logic e_nf, e_m2a, e_r2a, e_pch, e_wrd, e_wr, e_csel, e_saen, e_rv;
      e_vdr = '0; e_vss = '0; e_vrst = '0;
      {e_nf, e_m2a, e_r2a, e_pch, e_wrd, e_wr, e_csel, e_saen, e_rv} = '0;
      if (m_busy && m_write) begin
         if (m_k < m_p) e_pch = 1'b1;
         else begin
            e_wr = 1'b1; e_csel = 1'b1; e_wrd = m_wdata; e_vdr = m_rows;
         end
      end else if (m_busy) begin
         if (m_k < m_p) begin
            e_vrst = '1; e_pch = 1'b1;
         end else if (m_k == m_p) begin
            e_vdr = '0;
         end else if (m_k <= m_p + m_d) begin
            e_vdr = m_rows; e_vss = ~m_rows; e_m2a = 1'b1;
         end else if (m_k <= m_p + m_d + m_s) begin
            e_r2a = 1'b1; e_nf = 1'b1;
         end else if (m_k == m_p + m_d + m_s + 1) begin
            e_saen = 1'b1; e_nf = 1'b1;
         end else begin
            e_rv = 1'b1;
         end
      end
      check("req_ready", req_ready, !m_busy);
      check("rsp_valid", rsp_valid, e_rv);
      check("rsp_data", rsp_data, m_rsp);
      check("VDR_SEL", VDR_SEL, e_vdr);
      check("VSS_SEL", VSS_SEL, e_vss);
      check("VRST_SEL", VRST_SEL, e_vrst);
      check("ctl{NF,M2A,R2A,PCH,WRD,WR,CSEL,SAEN}",
            {NF, M2A, R2A, PCH, WR_DATA, WRITE, CSEL, SAEN},
            {e_nf, e_m2a, e_r2a, e_pch, e_wrd, e_wr, e_csel, e_saen});
      check("vdr_and_vss", VDR_SEL & VSS_SEL, '0);
      check("vrst_overlap", (|VRST_SEL) && ((|VDR_SEL) || (|VSS_SEL)), 1'b0);
      check("sel_b", {VDR_SELB ^ VDR_SEL, VSS_SELB ^ VSS_SEL, VRST_SELB ^ VRST_SEL} == {384{1'b1}}, 1'b1);
      check("ctl_b", {NFB ^ NF, M2AB ^ M2A, R2AB ^ R2A}, 3'b111);
   end

   // ---------------- stimulus ----------------
   logic [7:0] h_pch, h_vrst, h_gap, h_vdr1, h_m2a, h_r2a, h_saen;
   int r2a_cnt;

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check("wait_ready_bound", req_ready, 1'b1);
   endtask

   // Issues a compute and returns edges from the accept edge to rsp_valid.
   task automatic do_compute(input logic [127:0] rows, input logic [3:0] p, d, s,
                             input logic [31:0] sa, output int lat);
      wait_ready();
      req_op = 1'b0; req_rows = rows; cfg_pch = p; cfg_drv = d; cfg_shr = s;
      sa_out = sa; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cfg_pch = 4'd7; cfg_drv = 4'd7; cfg_shr = 4'd7;
      {h_pch, h_vrst, h_gap, h_vdr1, h_m2a, h_r2a, h_saen} = '0;
      r2a_cnt = 0;
      lat = 0;
      while (!rsp_valid && lat < 200) begin
         if (lat < 8) begin
            h_pch[lat]  = PCH;
            h_vrst[lat] = &VRST_SEL;
            h_gap[lat]  = (VDR_SEL == '0) && (VSS_SEL == '0) && (VRST_SEL == '0);
            h_vdr1[lat] = (VDR_SEL == 128'h1);
            h_m2a[lat]  = M2A;
            h_r2a[lat]  = R2A;
            h_saen[lat] = SAEN;
         end
         if (R2A) r2a_cnt++;
         @(posedge clk); #1; lat++;
      end
   endtask

   initial begin
      int lat;
      logic [7:0] w_pch_h, w_wr_h;
      int n;

      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_selb", {VDR_SELB, VSS_SELB, VRST_SELB} == {384{1'b1}}, 1'b1);
      check("rst_ctl_b", {NFB, M2AB, R2AB}, 3'b111);
      check("rst_rsp", {rsp_valid, rsp_data}, 33'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed compute with default phase lengths.
      do_compute(128'h1, 4'd2, 4'd2, 4'd2, 32'hA5A5_A5A5, lat);
      check("t1_latency", lat, 8);
      check("t1_rsp_data", rsp_data, 32'hA5A5_A5A5);
      check("t1_pch_win", h_pch, 8'b0000_0011);
      check("t1_vrst_win", h_vrst, 8'b0000_0011);
      check("t1_gap_win", h_gap, 8'b1110_0100);
      check("t1_vdr_win", h_vdr1, 8'b0001_1000);
      check("t1_m2a_win", h_m2a, 8'b0001_1000);
      check("t1_r2a_win", h_r2a, 8'b0110_0000);
      check("t1_saen_win", h_saen, 8'b1000_0000);

      // Walking-one row sweep with minimum phase lengths.
      for (int i = 0; i < 128; i++) begin
         do_compute(128'h1 << i, 4'd0, 4'd0, 4'd0, 32'(i) * 32'h0101_0101 ^ 32'h5A, lat);
         check("walk_latency", lat, 5);
      end

      // Zero lengths stretch to one; longest share phase.
      do_compute({64'hF0F0_0000_1234_5678, 64'h8000_0000_0000_0001}, 4'd0, 4'd0, 4'd15,
                 32'h0BAD_F00D, lat);
      check("t3_latency", lat, 19);
      check("t3_share_len", r2a_cnt, 15);
      check("t3_rsp_data", rsp_data, 32'h0BAD_F00D);

      // Write with one-hot row 64.
      wait_ready();
      req_op = 1'b1; req_rows = 128'h1 << 64; req_wdata = 1'b1;
      cfg_pch = 4'd3; cfg_drv = 4'd1; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; req_op = 1'b0;
      w_pch_h = '0; w_wr_h = '0; n = 0;
      while (!req_ready && n < 50) begin
         if (n < 8) begin
            w_pch_h[n] = PCH;
            w_wr_h[n]  = WRITE && CSEL && WR_DATA && VDR_SEL[64] && (VDR_SEL == (128'h1 << 64));
         end
         check("wr_no_rsp", rsp_valid, 1'b0);
         @(posedge clk); #1; n++;
      end
      check("wr_ready_edge", n, 4);
      check("wr_pch_win", w_pch_h, 8'b0000_0111);
      check("wr_wr_win", w_wr_h, 8'b0000_1000);

      // Backpressure: hold RESP while new requests knock.
      rsp_ready = 1'b0;
      do_compute(128'hFFFF, 4'd2, 4'd2, 4'd2, 32'hDEAD_BEEF, lat);
      check("bp_latency", lat, 8);
      sa_out = 32'h1111_2222;
      for (int j = 0; j < 10; j++) begin
         req_valid = j[0];
         req_rows = 128'h1 << (j + 3);
         @(posedge clk); #1;
         check("bp_hold_data", rsp_data, 32'hDEAD_BEEF);
         check("bp_hold_rdy", {req_ready, rsp_valid}, 2'b01);
      end
      req_valid = 1'b1; req_rows = 128'h3C; cfg_pch = 4'd2; cfg_drv = 4'd2; cfg_shr = 4'd2;
      sa_out = 32'h7777_8888; rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release", {req_ready, rsp_valid}, 2'b10);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("bp_accepted", req_ready, 1'b0);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check("bp_next_latency", n, 8);
      check("bp_next_data", rsp_data, 32'h7777_8888);

      // Async reset during DRIVE.
      wait_ready();
      req_op = 1'b0; req_rows = 128'h5; cfg_pch = 4'd2; cfg_drv = 4'd4; cfg_shr = 4'd2;
      sa_out = 32'hCAFE_0000; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!M2A && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("rst_test_in_drive", M2A, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("arst_sel", {VDR_SEL, VSS_SEL, VRST_SEL}, '0);
      check("arst_selb", {VDR_SELB, VSS_SELB, VRST_SELB} == {384{1'b1}}, 1'b1);
      check("arst_ctl", {NF, M2A, R2A, PCH, WR_DATA, WRITE, CSEL, SAEN, NFB, M2AB, R2AB},
            11'b000_0000_0111);
      check("arst_hs", {req_ready, rsp_valid, rsp_data}, {2'b10, 32'h0});
      @(posedge clk); #3;
      rst = 1'b0;
      do_compute(128'h9, 4'd2, 4'd2, 4'd2, 32'h1234_5678, lat);
      check("post_rst_latency", lat, 8);
      check("post_rst_data", rsp_data, 32'h1234_5678);
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
